hdmi_vtg_pattern: RTL and testbench

Parametrised video timing generator and test-pattern source. It drives a 16-bit YCbCr 4:2:2 parallel video bus (HDMI transmitter style) from a single pixel clock. Raster geometry and sync polarity are set by parameters. It adds the following:
- run/stop control with clean frame-boundary start and stop;
- pattern mode latched once per frame;
- colour bars, checkerboard, a bouncing box and a solid-colour mode;
- frame counter and start-of-frame marker.

It sits between the SI570-derived pixel clock domain and the HDMI output IOB registers.

---
 rtl/hdmi_vtg_pattern.sv | 215 +++++++++++++++++++++
 tb/tb_hdmi_vtg_pattern.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_vtg_pattern.sv
// Video timing generator with built-in test patterns for a 16-bit YCbCr 4:2:2 bus.
// Two-stage output pipeline: counter decode/pattern, then output registers.
module hdmi_vtg_pattern #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int BOX_SIZE = 128,
  parameter int CW       = 12
) (
  input  logic        sys2_clk,
  input  logic        sys2_rstn,
  input  logic        en,
  input  logic [3:0]  mode,
  input  logic [7:0]  solid_y,
  input  logic [7:0]  solid_c,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic [15:0] vid_data,
  output logic        vid_sof,
  output logic [15:0] frame_cnt,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_LIM  = CW'(H_ACTIVE - BOX_SIZE);
  localparam logic [CW-1:0] Y_LIM  = CW'(V_ACTIVE - BOX_SIZE);

  // Decode thresholds are one bit wider so sync windows ending at the total still fit
  localparam logic [CW:0] H_ACT    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_ACT    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] BOX_W    = (CW+1)'(BOX_SIZE);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] bx, by;
  logic          dx, dy;
  logic [3:0]    mode_l;
  logic [7:0]    sy_l, sc_l;

  logic          run_px, first_px, wrap;
  logic [CW:0]   hx, vx, bxx, byx;
  logic          active, hs_on, vs_on, in_box;
  logic [3:0]    cur_mode;
  logic [7:0]    cur_sy, cur_sc;
  logic [2:0]    bar;
  logic [7:0]    y_val, c_val;

  logic          s1_de, s1_hs, s1_vs, s1_sof;
  logic [15:0]   s1_data;

  assign run_px   = (state == RUN);
  assign first_px = run_px && (hcnt == '0) && (vcnt == '0);
  assign wrap     = run_px && (hcnt == H_LAST) && (vcnt == V_LAST);
  assign running  = run_px;

  always_ff @(posedge sys2_clk or negedge sys2_rstn) begin
    if (!sys2_rstn) state <= IDLE;
    else            state <= state_nxt;
  end

  // Stopping is only allowed at the frame wrap so a frame is never cut short
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (wrap && !en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys2_clk or negedge sys2_rstn) begin
    if (!sys2_rstn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run_px) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  // Per-frame state: frame count, box position, and latched pattern settings
  always_ff @(posedge sys2_clk or negedge sys2_rstn) begin
    if (!sys2_rstn) begin
      frame_cnt <= '0;
      bx        <= '0;
      by        <= '0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      mode_l    <= '0;
      sy_l      <= '0;
      sc_l      <= '0;
    end else begin
      if (first_px) begin
        mode_l <= mode;
        sy_l   <= solid_y;
        sc_l   <= solid_c;
      end
      if (wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (dx) begin
          bx <= bx + CW'(1);
          if (bx + CW'(1) == X_LIM) dx <= 1'b0;
        end else begin
          bx <= bx - CW'(1);
          if (bx == CW'(1)) dx <= 1'b1;
        end
        if (dy) begin
          by <= by + CW'(1);
          if (by + CW'(1) == Y_LIM) dy <= 1'b0;
        end else begin
          by <= by - CW'(1);
          if (by == CW'(1)) dy <= 1'b1;
        end
      end
    end
  end

  assign hx     = {1'b0, hcnt};
  assign vx     = {1'b0, vcnt};
  assign bxx    = {1'b0, bx};
  assign byx    = {1'b0, by};
  assign active = (hx < H_ACT) && (vx < V_ACT);
  assign hs_on  = (hx >= HS_START) && (hx < HS_END);
  assign vs_on  = (vx >= VS_START) && (vx < VS_END);
  assign in_box = (hx >= bxx) && (hx < bxx + BOX_W) && (vx >= byx) && (vx < byx + BOX_W);

  // Pixel (0,0) uses the live inputs since the latch only updates on that same cycle
  assign cur_mode = first_px ? mode    : mode_l;
  assign cur_sy   = first_px ? solid_y : sy_l;
  assign cur_sc   = first_px ? solid_c : sc_l;

  always_comb begin
    bar = '0;
    for (int j = 1; j < 8; j++) begin
      if (hx >= (CW+1)'(j * BAR_W)) bar = 3'(j);
    end
  end

  always_comb begin
    y_val = 8'h10;
    c_val = 8'h80;
    case (cur_mode)
      4'd0: y_val = hcnt[7:0];
      4'd1: y_val = vcnt[7:0];
      4'd2: y_val = {bar, 5'b0};
      4'd3: y_val = (hcnt[5] ^ vcnt[5]) ? 8'hEB : 8'h10;
      4'd4: y_val = in_box ? frame_cnt[7:0] : hcnt[7:0];
      4'd5: begin
        y_val = cur_sy;
        c_val = cur_sc;
      end
      default: y_val = 8'h10;
    endcase
  end

  always_ff @(posedge sys2_clk or negedge sys2_rstn) begin
    if (!sys2_rstn) begin
      s1_de   <= 1'b0;
      s1_hs   <= ~HS_ACT;
      s1_vs   <= ~VS_ACT;
      s1_sof  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_de   <= run_px && active;
      s1_hs   <= (run_px && hs_on) ? HS_ACT : ~HS_ACT;
      s1_vs   <= (run_px && vs_on) ? VS_ACT : ~VS_ACT;
      s1_sof  <= first_px;
      s1_data <= (run_px && active) ? {c_val, y_val} : 16'h0000;
    end
  end

  always_ff @(posedge sys2_clk or negedge sys2_rstn) begin
    if (!sys2_rstn) begin
      vid_de   <= 1'b0;
      vid_hs   <= ~HS_ACT;
      vid_vs   <= ~VS_ACT;
      vid_sof  <= 1'b0;
      vid_data <= '0;
    end else begin
      vid_de   <= s1_de;
      vid_hs   <= s1_hs;
      vid_vs   <= s1_vs;
      vid_sof  <= s1_sof;
      vid_data <= s1_data;
    end
  end

endmodule

// File: tb/tb_hdmi_vtg_pattern.sv
// Directed bench for hdmi_vtg_pattern on a small raster (24x12 totals), plus a
// wider instance used only for the checkerboard pattern.
module tb_hdmi_vtg_pattern;

  localparam int HA = 16, HF = 2, HSW = 2, HB = 4, HT = 24;
  localparam int VA = 8, VF = 1, VSW = 1, VB = 2, VT = 12;
  localparam int BOX = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [7:0]  sy = 8'h00;
  logic [7:0]  sc = 8'h00;
  logic        vid_de, vid_hs, vid_vs, vid_sof, running;
  logic [15:0] vid_data, frame_cnt;

  logic        en2 = 1'b0;
  logic        de2, hs2, vs2, sof2, running2;
  logic [15:0] data2, fcnt2;

  int total = 0;
  int bad = 0;
  int mfc = 0;
  int mbx = 0, mby = 0;
  bit mdx = 1'b1, mdy = 1'b1;

  always #5 clk = ~clk;

  hdmi_vtg_pattern #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .BOX_SIZE(BOX), .CW(12)
  ) dut (
    .sys2_clk(clk), .sys2_rstn(rstn), .en(en), .mode(mode),
    .solid_y(sy), .solid_c(sc),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_data(vid_data),
    .vid_sof(vid_sof), .frame_cnt(frame_cnt), .running(running)
  );

  hdmi_vtg_pattern #(
    .H_ACTIVE(128), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .BOX_SIZE(BOX), .CW(12)
  ) dut_wide (
    .sys2_clk(clk), .sys2_rstn(rstn), .en(en2), .mode(4'd3),
    .solid_y(8'h00), .solid_c(8'h00),
    .vid_de(de2), .vid_hs(hs2), .vid_vs(vs2), .vid_data(data2),
    .vid_sof(sof2), .frame_cnt(fcnt2), .running(running2)
  );

  // Expected {de, hs, vs, sof, data} for output pixel (h, v)
  function automatic logic [19:0] exp_word(input int h, input int v, input int md,
                                           input int y5, input int c5, input int fc,
                                           input int bx, input int by);
    logic act, hs, vs, sof;
    logic [7:0] y, c;
    int k;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HF) && (h < HA + HF + HSW);
    vs  = (v >= VA + VF) && (v < VA + VF + VSW);
    sof = (h == 0) && (v == 0);
    c = 8'h80;
    k = h / (HA / 8);
    if (k > 7) k = 7;
    case (md)
      0: y = 8'(h);
      1: y = 8'(v);
      2: y = 8'(32 * k);
      3: y = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 8'hEB : 8'h10;
      4: y = (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? 8'(fc) : 8'(h);
      5: begin y = 8'(y5); c = 8'(c5); end
      default: y = 8'h10;
    endcase
    return {act, hs, vs, sof, (act ? {c, y} : 16'h0000)};
  endfunction

  task automatic step_box();
    if (mdx) begin mbx++; if (mbx == HA - BOX) mdx = 1'b0; end
    else     begin mbx--; if (mbx == 0) mdx = 1'b1; end
    if (mdy) begin mby++; if (mby == VA - BOX) mdy = 1'b0; end
    else     begin mby--; if (mby == 0) mdy = 1'b1; end
  endtask

  // Starts on the negedge showing pixel (0,0); ends on the next frame's (0,0) slot
  task automatic check_frame(input int md, input int y5, input int c5,
                             input int nmd, input int ny5, input int nc5,
                             input logic nen, input logic ren);
    logic [19:0] got, want;
    int h, v;
    total++;
    if (frame_cnt !== 16'(mfc)) begin
      bad++;
      $display("[TB] FAIL frame_cnt at sof: got %0d want %0d", frame_cnt, mfc);
    end
    for (int i = 0; i < HT * VT; i++) begin
      h = i % HT;
      v = i / HT;
      if (i == 72) begin mode = 4'(nmd); sy = 8'(ny5); sc = 8'(nc5); en = nen; end
      if (i == 200) en = ren;
      got  = {vid_de, vid_hs, vid_vs, vid_sof, vid_data};
      want = exp_word(h, v, md, y5, c5, mfc, mbx, mby);
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL pixel f%0d (%0d,%0d) mode%0d: got %h want %h", mfc, h, v, md, got, want);
      end
      @(negedge clk);
    end
    mfc++;
    step_box();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en = 1'b0;
    #12;
    total += 7;
    if (vid_de !== 1'b0)     begin bad++; $display("[TB] FAIL reset de: got %b want 0", vid_de); end
    if (vid_hs !== 1'b0)     begin bad++; $display("[TB] FAIL reset hs: got %b want 0", vid_hs); end
    if (vid_vs !== 1'b0)     begin bad++; $display("[TB] FAIL reset vs: got %b want 0", vid_vs); end
    if (vid_data !== 16'h0)  begin bad++; $display("[TB] FAIL reset data: got %h want 0000", vid_data); end
    if (vid_sof !== 1'b0)    begin bad++; $display("[TB] FAIL reset sof: got %b want 0", vid_sof); end
    if (frame_cnt !== 16'h0) begin bad++; $display("[TB] FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
    if (running !== 1'b0)    begin bad++; $display("[TB] FAIL reset running: got %b want 0", running); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    total += 2;
    if (running !== 1'b0) begin bad++; $display("[TB] FAIL idle running: got %b want 0", running); end
    if (vid_de !== 1'b0)  begin bad++; $display("[TB] FAIL idle de: got %b want 0", vid_de); end
  endtask

  task automatic test_checker();
    int cnt;
    logic [15:0] want;
    en2 = 1'b1;
    cnt = 0;
    while (sof2 !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    total++;
    if (sof2 !== 1'b1) begin bad++; $display("[TB] FAIL checker sof timeout: got %b want 1", sof2); end
    en2 = 1'b0;
    for (int x = 0; x < 128; x++) begin
      want = ((x / 32) % 2 == 1) ? 16'h80EB : 16'h8010;
      total++;
      if (data2 !== want || de2 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL checker x=%0d: got de=%b data=%h want de=1 data=%h", x, de2, data2, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_startup();
    int cnt;
    mode = 4'd0;
    en = 1'b1;
    @(negedge clk);
    total++;
    if (running !== 1'b1) begin bad++; $display("[TB] FAIL start running: got %b want 1", running); end
    cnt = 1;
    while (vid_sof !== 1'b1 && cnt < 20) begin
      total++;
      if (vid_de !== 1'b0) begin bad++; $display("[TB] FAIL early de at %0d: got %b want 0", cnt, vid_de); end
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt !== 3) begin bad++; $display("[TB] FAIL sof latency: got %0d want 3", cnt); end
  endtask

  task automatic test_patterns();
    check_frame(0, 0, 0, 1, 0, 0, 1'b1, 1'b1);
    check_frame(1, 0, 0, 2, 0, 0, 1'b1, 1'b1);
    check_frame(2, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    check_frame(0, 0, 0, 5, 8'h51, 8'h3C, 1'b1, 1'b1);
    check_frame(5, 8'h51, 8'h3C, 3, 8'h51, 8'h3C, 1'b1, 1'b1);
    check_frame(3, 8'h51, 8'h3C, 4, 8'h51, 8'h3C, 1'b1, 1'b1);
  endtask

  task automatic test_box();
    for (int f = 0; f < 30; f++) begin
      if (f == 4) check_frame(4, 8'h51, 8'h3C, 4, 8'h51, 8'h3C, 1'b0, 1'b1);
      else        check_frame(4, 8'h51, 8'h3C, 4, 8'h51, 8'h3C, 1'b1, 1'b1);
    end
  endtask

  task automatic test_stop();
    check_frame(4, 8'h51, 8'h3C, 4, 8'h51, 8'h3C, 1'b0, 1'b0);
    total += 3;
    if (running !== 1'b0) begin bad++; $display("[TB] FAIL stop running: got %b want 0", running); end
    if (frame_cnt !== 16'(mfc)) begin bad++; $display("[TB] FAIL stop frame_cnt: got %0d want %0d", frame_cnt, mfc); end
    if ({vid_de, vid_hs, vid_vs, vid_sof, vid_data} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL stop outputs: got %h want 00000", {vid_de, vid_hs, vid_vs, vid_sof, vid_data});
    end
    repeat (30) @(negedge clk);
    total += 2;
    if (running !== 1'b0) begin bad++; $display("[TB] FAIL idle after stop running: got %b want 0", running); end
    if ({vid_de, vid_hs, vid_vs, vid_sof, vid_data} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL idle after stop outputs: got %h want 00000", {vid_de, vid_hs, vid_vs, vid_sof, vid_data});
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    mode = 4'd0;
    en = 1'b1;
    cnt = 0;
    while (vid_sof !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    total += 2;
    if (vid_data !== 16'h8000) begin bad++; $display("[TB] FAIL restart data: got %h want 8000", vid_data); end
    if (frame_cnt !== 16'(mfc)) begin bad++; $display("[TB] FAIL restart frame_cnt: got %0d want %0d", frame_cnt, mfc); end
    repeat (5) @(negedge clk);
    total++;
    if (vid_data !== 16'h8005) begin bad++; $display("[TB] FAIL pre-reset data: got %h want 8005", vid_data); end
    #2 rstn = 1'b0;
    #1;
    total += 3;
    if ({vid_de, vid_hs, vid_vs, vid_sof, vid_data} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL async reset outputs: got %h want 00000", {vid_de, vid_hs, vid_vs, vid_sof, vid_data});
    end
    if (frame_cnt !== 16'h0) begin bad++; $display("[TB] FAIL async reset frame_cnt: got %0d want 0", frame_cnt); end
    if (running !== 1'b0)    begin bad++; $display("[TB] FAIL async reset running: got %b want 0", running); end
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_checker();
    test_startup();
    test_patterns();
    test_box();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
